// File: rtl/pipe_ctrl.sv
// Y86 five-stage pipeline control: per-stage stall/bubble strobes, a RUN/MEM_WAIT/HALT
// sequencer for data-memory waits and terminal halt, and a saturating fetch-stall counter.
module pipe_ctrl #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       M_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_Cnd_i,
    input  logic [2:0]       m_stat_i,
    input  logic [2:0]       W_stat_i,
    input  logic             M_memreq_i,
    input  logic             dmem_ready_i,
    input  logic             imem_ready_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             E_stall_o,
    output logic             M_stall_o,
    output logic             W_stall_o,
    output logic             F_bubble_o,
    output logic             D_bubble_o,
    output logic             E_bubble_o,
    output logic             M_bubble_o,
    output logic             W_bubble_o,
    output logic             halted_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IMRMOVL = 4'h5;
    localparam logic [3:0] IPOPL   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SHLT    = 3'd2;
    localparam logic [2:0] SADR    = 3'd3;
    localparam logic [2:0] SINS    = 3'd4;

    localparam int WCW = $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_e;

    typedef struct packed {
        logic f;
        logic d;
        logic e;
        logic m;
        logic w;
    } stage_t;

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;

    stage_t stall_s, bubble_s;

    logic load_use, ret_hz, mispredict, m_exc, w_exc, imem_wait, wait_start;

    always_comb begin
        load_use   = (E_icode_i == IMRMOVL || E_icode_i == IPOPL) && (E_dstM_i != RNONE) &&
                     (E_dstM_i == d_srcA_i || E_dstM_i == d_srcB_i);
        ret_hz     = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
        mispredict = (E_icode_i == IJXX) && !e_Cnd_i;
        m_exc      = (m_stat_i == SADR) || (m_stat_i == SINS) || (m_stat_i == SHLT);
        w_exc      = (W_stat_i != SAOK);
        imem_wait  = !imem_ready_i;
        wait_start = M_memreq_i && !dmem_ready_i;
    end

    // Strobes are combinational so the pipeline registers react in the same cycle.
    always_comb begin
        // NOTE: every output gets a default first, so no path through this block infers a latch.
        stall_s  = '0;
        bubble_s = '0;
        if (!rst_n_i) begin
            bubble_s = '1;
        end else begin
            unique case (state_q)
                HALT: stall_s = '1;
                MEM_WAIT: begin
                    stall_s    = '{f: 1'b1, d: 1'b1, e: 1'b1, m: 1'b1, w: 1'b0};
                    bubble_s.w = 1'b1;
                end
                default: begin
                    if (wait_start) begin
                        stall_s    = '{f: 1'b1, d: 1'b1, e: 1'b1, m: 1'b1, w: 1'b0};
                        bubble_s.w = 1'b1;
                    end else begin
                        stall_s.f  = load_use || ret_hz || imem_wait;
                        stall_s.d  = load_use;
                        stall_s.w  = w_exc;
                        bubble_s.d = ret_hz || mispredict || imem_wait;
                        bubble_s.e = load_use || mispredict || m_exc || w_exc;
                        bubble_s.m = m_exc || w_exc;
                    end
                end
            endcase
            // A stalled stage must keep its contents, so stall always beats bubble.
            bubble_s = bubble_s & ~stall_s;
        end
    end

    always_comb begin
        state_d    = state_q;
        timeout_d  = timeout_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (wait_start) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready_i) begin
                    state_d = RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (w_exc) state_d = HALT;
        halted_d = halted_q || (state_d == HALT);
        cnt_d    = (stall_s.f && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= RUN;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign {F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o}      = stall_s;
    assign {F_bubble_o, D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o} = bubble_s;
    assign halted_o    = halted_q;
    assign timeout_o   = timeout_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus WAIT_MAX=3 and CNT_W=4 variants
// driven by the same stimulus; strobe expectations flow through a scoreboard queue.
module tb_pipe_ctrl;

    localparam logic [9:0] F_ST = 10'h200, D_ST = 10'h100, E_ST = 10'h080, M_ST = 10'h040,
                           W_ST = 10'h020, F_BU = 10'h010, D_BU = 10'h008, E_BU = 10'h004,
                           M_BU = 10'h002, W_BU = 10'h001;
    localparam logic [9:0] ALL_BU   = F_BU | D_BU | E_BU | M_BU | W_BU;
    localparam logic [9:0] WAIT_PAT = F_ST | D_ST | E_ST | M_ST | W_BU;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [3:0] D_icode_i, E_icode_i, M_icode_i, d_srcA_i, d_srcB_i, E_dstM_i;
    logic       e_Cnd_i, M_memreq_i, dmem_ready_i, imem_ready_i;
    logic [2:0] m_stat_i, W_stat_i;

    logic [9:0]  st0, st_t, st_c;
    logic        halted0, timeout0, halted_t, timeout_t, halted_c, timeout_c;
    logic [15:0] cnt0, cnt_t;
    logic [3:0]  cnt_c;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk_i = ~clk_i;

    pipe_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .D_icode_i(D_icode_i), .E_icode_i(E_icode_i),
        .M_icode_i(M_icode_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i), .E_dstM_i(E_dstM_i),
        .e_Cnd_i(e_Cnd_i), .m_stat_i(m_stat_i), .W_stat_i(W_stat_i), .M_memreq_i(M_memreq_i),
        .dmem_ready_i(dmem_ready_i), .imem_ready_i(imem_ready_i),
        .F_stall_o(st0[9]), .D_stall_o(st0[8]), .E_stall_o(st0[7]), .M_stall_o(st0[6]),
        .W_stall_o(st0[5]), .F_bubble_o(st0[4]), .D_bubble_o(st0[3]), .E_bubble_o(st0[2]),
        .M_bubble_o(st0[1]), .W_bubble_o(st0[0]),
        .halted_o(halted0), .timeout_o(timeout0), .stall_cnt_o(cnt0)
    );

    pipe_ctrl #(.WAIT_MAX(3)) dut_t (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .D_icode_i(D_icode_i), .E_icode_i(E_icode_i),
        .M_icode_i(M_icode_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i), .E_dstM_i(E_dstM_i),
        .e_Cnd_i(e_Cnd_i), .m_stat_i(m_stat_i), .W_stat_i(W_stat_i), .M_memreq_i(M_memreq_i),
        .dmem_ready_i(dmem_ready_i), .imem_ready_i(imem_ready_i),
        .F_stall_o(st_t[9]), .D_stall_o(st_t[8]), .E_stall_o(st_t[7]), .M_stall_o(st_t[6]),
        .W_stall_o(st_t[5]), .F_bubble_o(st_t[4]), .D_bubble_o(st_t[3]), .E_bubble_o(st_t[2]),
        .M_bubble_o(st_t[1]), .W_bubble_o(st_t[0]),
        .halted_o(halted_t), .timeout_o(timeout_t), .stall_cnt_o(cnt_t)
    );

    pipe_ctrl #(.CNT_W(4)) dut_c (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .D_icode_i(D_icode_i), .E_icode_i(E_icode_i),
        .M_icode_i(M_icode_i), .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i), .E_dstM_i(E_dstM_i),
        .e_Cnd_i(e_Cnd_i), .m_stat_i(m_stat_i), .W_stat_i(W_stat_i), .M_memreq_i(M_memreq_i),
        .dmem_ready_i(dmem_ready_i), .imem_ready_i(imem_ready_i),
        .F_stall_o(st_c[9]), .D_stall_o(st_c[8]), .E_stall_o(st_c[7]), .M_stall_o(st_c[6]),
        .W_stall_o(st_c[5]), .F_bubble_o(st_c[4]), .D_bubble_o(st_c[3]), .E_bubble_o(st_c[2]),
        .M_bubble_o(st_c[1]), .W_bubble_o(st_c[0]),
        .halted_o(halted_c), .timeout_o(timeout_c), .stall_cnt_o(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        D_icode_i = 4'h1; E_icode_i = 4'h1; M_icode_i = 4'h1;
        d_srcA_i = 4'hF; d_srcB_i = 4'hF; E_dstM_i = 4'hF;
        e_Cnd_i = 1'b1; m_stat_i = 3'd1; W_stat_i = 3'd1;
        M_memreq_i = 1'b0; dmem_ready_i = 1'b1; imem_ready_i = 1'b1;
    endtask

    // Inputs are already driven (at a falling edge); push the expectation, sample, pop, compare.
    task automatic step(input string tag, input logic [9:0] exp);
        sb_item_t item;
        sb.push_back('{tag: tag, exp: exp});
        #2;
        item = sb.pop_front();
        check(item.tag, {22'd0, st0}, {22'd0, item.exp});
        if (exp[9]) exp_cnt++;
        @(negedge clk_i);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cnt"}, {16'd0, cnt0}, exp_cnt);
        check({tag, "_cnt4"}, {28'd0, cnt_c}, (exp_cnt > 15) ? 15 : exp_cnt);
    endtask

    initial begin
        idle();
        rst_n_i = 1'b0;
        #1;
        check("rst_strobes", {22'd0, st0}, {22'd0, ALL_BU});
        check("rst_cnt", {16'd0, cnt0}, 0);
        check("rst_halted", {31'd0, halted0}, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        step("idle", 10'h000);

        E_icode_i = 4'h5; E_dstM_i = 4'h3; d_srcA_i = 4'h3;
        step("load_use", F_ST | D_ST | E_BU);
        d_srcA_i = 4'hF; E_dstM_i = 4'hF;
        step("load_use_rnone", 10'h000);

        E_icode_i = 4'h1; D_icode_i = 4'h9;
        for (int i = 0; i < 3; i++) step("ret", F_ST | D_BU);
        E_icode_i = 4'h5; E_dstM_i = 4'h3; d_srcA_i = 4'h3;
        step("ret_load_use", F_ST | D_ST | E_BU);

        idle();
        E_icode_i = 4'h7; e_Cnd_i = 1'b0;
        step("mispredict", D_BU | E_BU);
        idle();
        imem_ready_i = 1'b0;
        step("imem_wait", F_ST | D_BU);
        idle();
        #1 check_counts("hazards");

        E_icode_i = 4'h5; E_dstM_i = 4'h3; d_srcA_i = 4'h3;
        M_memreq_i = 1'b1; dmem_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) step("mem_wait", WAIT_PAT);
        dmem_ready_i = 1'b1;
        #1;
        check("wmax3_timeout", {31'd0, timeout_t}, 1);
        check("wmax3_halted", {31'd0, halted_t}, 1);
        check("wait_no_timeout", {31'd0, timeout0}, 0);
        step("mem_ready_cycle", WAIT_PAT);
        M_memreq_i = 1'b0;
        step("back_to_run", F_ST | D_ST | E_BU);
        #1 check_counts("mem");

        idle();
        imem_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) step("sat_fstall", F_ST | D_BU);
        #1 check_counts("sat");

        idle();
        W_stat_i = 3'd2;
        step("halt_trigger", W_ST | E_BU | M_BU);
        W_stat_i = 3'd1;
        for (int i = 0; i < 3; i++) begin
            #1 check("halted", {31'd0, halted0}, 1);
            #0 step("halt_hold", F_ST | D_ST | E_ST | M_ST | W_ST);
        end
        check("halt_no_timeout", {31'd0, timeout0}, 0);

        E_icode_i = 4'h5; E_dstM_i = 4'h3; d_srcA_i = 4'h3; imem_ready_i = 1'b0;
        #3 rst_n_i = 1'b0;
        #1;
        check("midrst_strobes", {22'd0, st0}, {22'd0, ALL_BU});
        check("midrst_cnt", {16'd0, cnt0}, 0);
        check("midrst_halted", {31'd0, halted0}, 0);
        check("midrst_timeout_t", {31'd0, timeout_t}, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        exp_cnt = 0;
        step("post_rst_load_use", F_ST | D_ST | E_BU);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
